hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// Pipeline hazard controller for the 5-stage MIPS core. Keeps a per-register
// scoreboard of pending writebacks from loads and the shared multicycle
// divider. Decides each cycle whether the instruction in ID issues, stalls
// (with a bubble into EX) or is flushed. Drives the stage stall vector and
// issues the one-cycle start pulse to the single shared divider.
// PARAMETERS
// LOAD_LAT   1   cycles a load destination stays blocked after issue
// DIV_LAT    32  cycles a div destination and the divider stay busy after issue
// CNT_W      6   width of each scoreboard counter; must hold max(LOAD_LAT,DIV_LAT)
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   reset, asynchronous, active-low
// id_valid     in   1   ID holds a real instruction
// id_re1       in   1   ID reads source 1
// id_raddr1    in   5   source 1 register
// id_re2       in   1   ID reads source 2
// id_raddr2    in   5   source 2 register
// id_we        in   1   ID writes a destination
// id_waddr     in   5   destination register
// id_is_load   in   1   ID instruction is a load
// id_is_div    in   1   ID instruction is div/divu
// ex_flush     in   1   branch/exception redirect resolved this cycle
// mem_stall    in   1   data memory wait; freezes PC..MEM
// stall        out  6   [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold
// flush        out  1   clear IF/ID and ID/EX this cycle
// div_start    out  1   one-cycle divider start
// div_busy     out  1   divider occupied
// stall_cycles out  32  saturating count of cycles with stall[2]=1
// BEHAVIOUR
// - State: cnt[1..31] (CNT_W bits each), div_cnt (CNT_W), stall_cycles. r0 is never tracked.
// - Reset (rst=0, async): all cnt=0, div_cnt=0, stall_cycles=0. Outputs: stall=0,
//   flush=0, div_start=0, div_busy=0.
// - stall, flush and div_start are combinational from the current state and ID inputs.
// - hazard = id_valid & ( (id_re1 & raddr1!=0 & cnt[raddr1]!=0)
//   | (id_re2 & raddr2!=0 & cnt[raddr2]!=0) | (id_we & waddr!=0 & cnt[waddr]!=0)
//   | (id_is_div & div_cnt!=0) ).
// - Priority, high to low:
//   1) mem_stall=1: stall=6'b011111, flush=0, no issue. Counters and div_cnt frozen.
//   2) ex_flush=1: stall=0, flush=1, no issue. Counters keep decrementing, because
//      in-flight ops past EX still commit.
//   3) hazard=1: stall=6'b000111, i.e. bubble into EX. Counters decrement.
//   4) else: stall=0, and the instruction issues if id_valid.
// - Issue of a load with id_we and waddr!=0: cnt[waddr] <= LOAD_LAT.
// - Issue of a div: div_start=1, div_cnt <= DIV_LAT. If id_we and waddr!=0,
//   cnt[waddr] <= DIV_LAT.
// - ALU results are forwarded and never set a counter.
// - Every cycle without mem_stall, each nonzero counter and div_cnt decrements by 1.
//   On the same entry, a set takes precedence over a decrement; WAW blocking means
//   a set only hits a zero entry.
// - Timing: after issue in cycle t, a dependent ID instruction stalls in cycles
//   t+1..t+LAT and issues no earlier than cycle t+LAT+1.
// - div_busy = (div_cnt!=0).
// - stall_cycles increments when stall[2]=1 (either cause) and saturates at 32'hFFFFFFFF.
// - Reset mid-operation clears the scoreboard immediately. The divider must be
//   reset on the same rst.
// TESTING
// - Reset, then load to r5 followed by "add r6,r5,r1" in ID next cycle -> exactly
//   1 cycle of stall=6'b000111, then issue; stall_cycles=1.
// - div writing r8, then an independent ALU op, then a read of r8 -> ALU op issues
//   at once; the r8 reader stalls until 32 cycles after the div issue; div_start
//   pulses once.
// - Two back-to-back divs on different destinations -> second stalls until
//   div_busy falls, then div_start pulses for it.
// - Load to r5 issued, then ex_flush=1 while a dependent is in ID -> flush=1,
//   stall=0, no issue; cnt[r5] still expires on schedule.
// - mem_stall=1 for 3 cycles while cnt[r5]=1 -> stall=6'b011111, counter held at 1;
//   r5 reader issues 2 cycles after mem_stall drops.
// - Load to r0 and reads of r0 -> never stall. Assert rst low mid-div ->
//   div_busy=0 and stall=0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: per-register writeback scoreboard for
// loads and the shared divider, plus issue/stall/flush decision for the ID stage.
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_re1,
    input  logic [4:0]  id_raddr1,
    input  logic        id_re2,
    input  logic [4:0]  id_raddr2,
    input  logic        id_we,
    input  logic [4:0]  id_waddr,
    input  logic        id_is_load,
    input  logic        id_is_div,
    input  logic        ex_flush,
    input  logic        mem_stall,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        div_start,
    output logic        div_busy,
    output logic [31:0] stall_cycles
);

    // Entry 0 exists only to keep indexing simple; it is never set.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             blk1, blk2, blkw, blkd, hazard, issue;

    always_comb begin
        blk1   = id_re1 && (id_raddr1 != 5'd0) && (cnt_q[id_raddr1] != '0);
        blk2   = id_re2 && (id_raddr2 != 5'd0) && (cnt_q[id_raddr2] != '0);
        blkw   = id_we  && (id_waddr  != 5'd0) && (cnt_q[id_waddr]  != '0);
        blkd   = id_is_div && (div_cnt_q != '0);
        hazard = id_valid && (blk1 || blk2 || blkw || blkd);

        stall = 6'b000000;
        flush = 1'b0;
        issue = 1'b0;
        // Outputs are forced quiet while reset is held, even with mem_stall up.
        if (!rst) begin
            stall = 6'b000000;
        end else if (mem_stall) begin
            stall = 6'b011111;
        end else if (ex_flush) begin
            flush = 1'b1;
        end else if (hazard) begin
            stall = 6'b000111;
        end else begin
            issue = id_valid;
        end
        div_start = issue && id_is_div;
        div_busy  = (div_cnt_q != '0);
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = (cnt_q[i] != '0 && !mem_stall) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
        div_cnt_d = (div_cnt_q != '0 && !mem_stall) ? div_cnt_q - 1'b1 : div_cnt_q;

        // A set wins over the decrement; WAW blocking guarantees the entry was zero.
        if (issue && id_we && id_waddr != 5'd0) begin
            if (id_is_div)
                cnt_d[id_waddr] = CNT_W'(DIV_LAT);
            else if (id_is_load)
                cnt_d[id_waddr] = CNT_W'(LOAD_LAT);
        end
        if (div_start)
            div_cnt_d = CNT_W'(DIV_LAT);

        stall_cycles_d = stall_cycles_q;
        if (stall[2] && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
            div_cnt_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            div_cnt_q      <= div_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a model
// that tracks, per register, the point in unfrozen time when it becomes readable.
module tb_hazard_ctrl;
    localparam int LOAD_LAT = 1;
    localparam int DIV_LAT  = 32;
    localparam int CNT_W    = 6;

    logic        clk = 1'b0, rst = 1'b0;
    logic        id_valid = 0, id_re1 = 0, id_re2 = 0, id_we = 0;
    logic [4:0]  id_raddr1 = 0, id_raddr2 = 0, id_waddr = 0;
    logic        id_is_load = 0, id_is_div = 0, ex_flush = 0, mem_stall = 0;
    logic [5:0]  stall;
    logic        flush, div_start, div_busy;
    logic [31:0] stall_cycles;

    hazard_ctrl #(.LOAD_LAT(LOAD_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_re1(id_re1), .id_raddr1(id_raddr1),
        .id_re2(id_re2), .id_raddr2(id_raddr2), .id_we(id_we), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_div(id_is_div), .ex_flush(ex_flush),
        .mem_stall(mem_stall), .stall(stall), .flush(flush), .div_start(div_start),
        .div_busy(div_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: "progress" counts cycles not frozen by mem_stall; a register is
    // blocked while progress is below the point recorded at its producer's issue.
    int          progress;
    int          ready_at [32];
    int          div_ready_at;
    int unsigned m_stalls;
    logic [5:0]  e_stall;
    logic        e_flush, e_start, e_issue, e_busy;

    task automatic model_reset();
        progress = 0;
        foreach (ready_at[i]) ready_at[i] = 0;
        div_ready_at = 0;
        m_stalls = 0;
    endtask

    function automatic logic blk(input logic [4:0] r);
        return (r != 5'd0) && (progress < ready_at[r]);
    endfunction

    task automatic drive(input logic v, input logic re1, input logic [4:0] a1,
                         input logic re2, input logic [4:0] a2, input logic we,
                         input logic [4:0] wa, input logic ld, input logic dv,
                         input logic fl, input logic ms);
        logic hz;
        id_valid = v; id_re1 = re1; id_raddr1 = a1; id_re2 = re2; id_raddr2 = a2;
        id_we = we; id_waddr = wa; id_is_load = ld; id_is_div = dv;
        ex_flush = fl; mem_stall = ms;
        hz = v && ((re1 && blk(a1)) || (re2 && blk(a2)) || (we && blk(wa)) ||
                   (dv && progress < div_ready_at));
        e_stall = 6'b0; e_flush = 0; e_issue = 0;
        if (ms)      e_stall = 6'b011111;
        else if (fl) e_flush = 1;
        else if (hz) e_stall = 6'b000111;
        else         e_issue = v;
        e_start = e_issue && dv;
        e_busy  = progress < div_ready_at;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!mem_stall) begin
            if (e_issue && id_we && id_waddr != 0) begin
                if (id_is_div)       ready_at[id_waddr] = progress + 1 + DIV_LAT;
                else if (id_is_load) ready_at[id_waddr] = progress + 1 + LOAD_LAT;
            end
            if (e_start) div_ready_at = progress + 1 + DIV_LAT;
            progress++;
        end
        if (e_stall[2] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1, 1, 3, 0, 0, 1, 4, 0, 1, 0, 1);
        checks++;
        if (stall !== 6'b0 || flush !== 1'b0 || div_start !== 1'b0 || div_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b flush=%b start=%b busy=%b want all 0",
                     stall, flush, div_start, div_busy);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL load_issue stall=%b want 000000", stall); end
        tick();
        drive(1, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b000111) begin errors++; $display("FAIL load_use_stall stall=%b want 000111", stall); end
        tick();
        drive(1, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL load_use_issue stall=%b want 000000", stall); end
        tick();
        idle();
        checks++;
        if (stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", stall_cycles); end
    endtask

    task automatic test_div_reader();
        int n = 0, starts = 0;
        apply_reset();
        drive(1, 1, 2, 1, 3, 1, 8, 0, 1, 0, 0);
        if (div_start === 1'b1) starts++;
        tick();
        drive(1, 1, 2, 1, 3, 1, 9, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL div_indep_alu stall=%b want 000000", stall); end
        if (div_start === 1'b1) starts++;
        tick();
        drive(1, 1, 8, 0, 0, 1, 10, 0, 0, 0, 0);
        while (stall !== 6'b0 && n < 40) begin
            if (div_start === 1'b1) starts++;
            n++; tick();
            drive(1, 1, 8, 0, 0, 1, 10, 0, 0, 0, 0);
        end
        checks++;
        if (n != DIV_LAT - 1) begin errors++; $display("FAIL div_reader_stalls got %0d want %0d", n, DIV_LAT - 1); end
        checks++;
        if (div_busy !== 1'b0) begin errors++; $display("FAIL div_busy_after got %b want 0", div_busy); end
        tick(); idle();
        checks++;
        if (starts != 1) begin errors++; $display("FAIL div_start_pulses got %0d want 1", starts); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        apply_reset();
        drive(1, 1, 2, 1, 3, 1, 8, 0, 1, 0, 0);
        tick();
        drive(1, 1, 4, 1, 5, 1, 9, 0, 1, 0, 0);
        while (stall !== 6'b0 && n < 40) begin
            if (div_busy !== 1'b1 || div_start !== 1'b0) begin
                errors++; $display("FAIL div2_wait busy=%b start=%b want 1/0", div_busy, div_start);
            end
            n++; tick();
            drive(1, 1, 4, 1, 5, 1, 9, 0, 1, 0, 0);
        end
        checks++;
        if (n != DIV_LAT) begin errors++; $display("FAIL div2_stalls got %0d want %0d", n, DIV_LAT); end
        checks++;
        if (div_start !== 1'b1 || div_busy !== 1'b0) begin
            errors++; $display("FAIL div2_start start=%b busy=%b want 1/0", div_start, div_busy);
        end
        tick(); idle();
        checks++;
        if (div_busy !== 1'b1) begin errors++; $display("FAIL div2_busy got %b want 1", div_busy); end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0);
        tick();
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 1, 0);
        checks++;
        if (flush !== 1'b1 || stall !== 6'b0) begin
            errors++; $display("FAIL flush_dep flush=%b stall=%b want 1/000000", flush, stall);
        end
        tick();
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL flush_expire stall=%b flush=%b want 000000/0", stall, flush);
        end
        tick(); idle();
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL flush_count got %0d want 0", stall_cycles); end
    endtask

    task automatic test_mem_stall();
        apply_reset();
        drive(1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 1);
            checks++;
            if (stall !== 6'b011111) begin errors++; $display("FAIL mem_stall_vec stall=%b want 011111", stall); end
            tick();
        end
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b000111) begin errors++; $display("FAIL mem_stall_held stall=%b want 000111", stall); end
        tick();
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL mem_stall_issue stall=%b want 000000", stall); end
        tick(); idle();
        checks++;
        if (stall_cycles !== 32'd4) begin errors++; $display("FAIL mem_stall_count got %0d want 4", stall_cycles); end
    endtask

    task automatic test_r0();
        apply_reset();
        drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL r0_load stall=%b want 000000", stall); end
        tick();
        drive(1, 1, 2, 0, 0, 1, 0, 0, 1, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL r0_div stall=%b want 000000", stall); end
        tick(); idle();
    endtask

    task automatic test_reset_mid_div();
        apply_reset();
        drive(1, 1, 2, 0, 0, 1, 8, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin idle(); tick(); end
        drive(1, 1, 8, 0, 0, 1, 9, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b000111 || div_busy !== 1'b1) begin
            errors++; $display("FAIL middiv_pre stall=%b busy=%b want 000111/1", stall, div_busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (stall !== 6'b0 || div_busy !== 1'b0) begin
            errors++; $display("FAIL middiv_async stall=%b busy=%b want 000000/0", stall, div_busy);
        end
        @(negedge clk);
        model_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        drive(1, 1, 8, 0, 0, 1, 9, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL middiv_after stall=%b want 000000", stall); end
        tick(); idle();
    endtask

    task automatic test_random();
        logic ld, dv;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            checks++;
            if (stall_cycles !== m_stalls) begin
                errors++; $display("FAIL rnd_count cyc=%0d got %0d want %0d", c, stall_cycles, m_stalls);
            end
            dv = ($urandom_range(0, 15) == 0);
            ld = !dv && ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 4) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), ld, dv,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            checks++;
            if (stall !== e_stall || flush !== e_flush || div_start !== e_start || div_busy !== e_busy) begin
                errors++;
                $display("FAIL rnd_out cyc=%0d stall=%b flush=%b start=%b busy=%b want %b/%b/%b/%b",
                         c, stall, flush, div_start, div_busy, e_stall, e_flush, e_start, e_busy);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_div_reader();
        test_back_to_back();
        test_flush();
        test_mem_stall();
        test_r0();
        test_reset_mid_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
